// File: rtl/pc_gen_if.sv
// pc_gen_if -- bundles the fetch-head control and status signals of pc_gen.
//
// Master side (controller / pipeline / testbench) drives:
//   stall          hold the PC this cycle
//   redirect_valid load the computed target this cycle
//   redirect_sel   0 branch, 1 jump, 2 register, 3 return
//   base           branch/jump base (PC+1 of the control instruction)
//   imm            signed branch offset
//   target         pseudo-direct jump target field
//   reg_target     register-indirect target
//   push_valid     push push_addr onto the return-address stack
//   push_addr      return address to push
// Slave side (pc_gen) drives, all registered:
//   pc             current PC
//   ras_count      valid return-stack entries
//   ras_underflow  one-cycle pulse after a return popped an empty stack
//   ras_overflow   sticky: a push happened while the stack was full
interface pc_gen_if #(
  parameter int WIDTH        = 16,
  parameter int IMM_WIDTH    = 8,
  parameter int TARGET_WIDTH = 12,
  parameter int RAS_DEPTH    = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic                    stall;
  logic                    redirect_valid;
  logic [1:0]              redirect_sel;
  logic [WIDTH-1:0]        base;
  logic [IMM_WIDTH-1:0]    imm;
  logic [TARGET_WIDTH-1:0] target;
  logic [WIDTH-1:0]        reg_target;
  logic                    push_valid;
  logic [WIDTH-1:0]        push_addr;
  logic [WIDTH-1:0]        pc;
  logic [CW-1:0]           ras_count;
  logic                    ras_underflow;
  logic                    ras_overflow;

  modport master (
    output stall, redirect_valid, redirect_sel, base, imm, target, reg_target,
           push_valid, push_addr,
    input  pc, ras_count, ras_underflow, ras_overflow
  );

  modport slave (
    input  stall, redirect_valid, redirect_sel, base, imm, target, reg_target,
           push_valid, push_addr,
    output pc, ras_count, ras_underflow, ras_overflow
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator at the head of the fetch stage.
//
// Holds the architectural PC and picks its successor each cycle:
// increment, PC-relative branch, pseudo-direct jump, register-indirect jump,
// or a procedure return served by an optional return-address stack (RAS).
// Priority: reset > redirect_valid > stall > increment.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    pc_gen_if.slave (control inputs in, pc and RAS status out)
//
// Build option: define PC_GEN_RAS_EN to implement the return-address stack.
// Without it, sel 3 acts as sel 2, pushes are ignored and the RAS status
// outputs are tied to 0. The port list is the same in both builds.
module pc_gen #(
  parameter int               WIDTH        = 16,
  parameter int               IMM_WIDTH    = 8,
  parameter int               TARGET_WIDTH = 12,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_BRANCH = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_REG    = 2'd2,
    SEL_RET    = 2'd3
  } redirect_sel_e;

  redirect_sel_e    sel;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] target_pc;
  logic [WIDTH-1:0] pc_q, pc_d;

  assign sel     = redirect_sel_e'(bus.redirect_sel);
  assign imm_ext = {{(WIDTH-IMM_WIDTH){bus.imm[IMM_WIDTH-1]}}, bus.imm};

`ifdef PC_GEN_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d, top_inc, top_dec, wr_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             uf_q, uf_d, of_q, of_d;
  logic             pop, push, wr_en, ras_empty, ras_full;

  assign pop       = bus.redirect_valid && (sel == SEL_RET);
  assign push      = bus.push_valid;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CW'(RAS_DEPTH));

  // The stack is circular, so the pointer wraps at RAS_DEPTH, which need
  // not be a power of two.
  assign top_inc = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);

  // NOTE: every signal gets a default before any branch so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    of_d    = of_q;
    uf_d    = pop && ras_empty;
    wr_en   = 1'b0;
    wr_idx  = top_inc;
    if (push && pop && !ras_empty) begin
      // Return and call in the same cycle: the return consumes the old top
      // and the call's address takes its slot, so depth is unchanged.
      wr_en  = 1'b1;
      wr_idx = top_q;
    end else if (push) begin
      // Also covers push plus pop-on-empty, which leaves one entry.
      wr_en  = 1'b1;
      top_d  = top_inc;
      if (ras_full) of_d    = 1'b1;            // oldest entry overwritten
      else          count_d = count_q + CW'(1);
    end else if (pop && !ras_empty) begin
      top_d   = top_dec;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  // NOTE: the stack storage has no reset; entries are only read while
  // count marks them valid, so clearing them would serve no purpose.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) ras_mem[wr_idx] <= bus.push_addr;
  end

  assign bus.ras_count     = count_q;
  assign bus.ras_underflow = uf_q;
  assign bus.ras_overflow  = of_q;
`else
  // Push inputs have no function in this build.
  logic ras_unused;
  assign ras_unused = &{1'b0, bus.push_valid, bus.push_addr};

  assign bus.ras_count     = CW'(0);
  assign bus.ras_underflow = 1'b0;
  assign bus.ras_overflow  = 1'b0;
`endif

  always_comb begin
    target_pc = bus.reg_target;
    case (sel)
      SEL_BRANCH: target_pc = bus.base + imm_ext;
      SEL_JUMP:   target_pc = {bus.base[WIDTH-1:TARGET_WIDTH], bus.target};
      SEL_REG:    target_pc = bus.reg_target;
      SEL_RET: begin
`ifdef PC_GEN_RAS_EN
        // The pop target is read from the stack as it was before this edge.
        target_pc = ras_empty ? bus.reg_target : ras_mem[top_q];
`else
        target_pc = bus.reg_target;
`endif
      end
      default:    target_pc = bus.reg_target;
    endcase
  end

  always_comb begin
    pc_d = pc_q + WIDTH'(1);                   // wraps all-ones -> 0
    if (bus.redirect_valid) pc_d = target_pc;  // redirect beats stall
    else if (bus.stall)     pc_d = pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign bus.pc = pc_q;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the multi-cycle/pipelined CPU datapath. Holds the architectural PC and computes its successor each cycle:
- sequential increment
- PC-relative branch (sign-extended immediate)
- pseudo-direct jump (base upper bits concatenated with a target field)
- register-indirect jump

An optional return-address stack (RAS) supplies targets for procedure returns. Sits at the head of the fetch stage; the controller drives redirects, the pipeline drives stall.

## Interface
Parameters:
- WIDTH, 16, PC/data width
- IMM_WIDTH, 8, branch offset width (signed, < WIDTH)
- TARGET_WIDTH, 12, jump target field width (< WIDTH)
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return stack entries (>= 2; used only with RAS_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC (no increment)
- redirect_valid  in  1  load computed target this cycle
- redirect_sel  in  2  0 branch, 1 jump, 2 register, 3 return
- base  in  WIDTH  branch/jump base (caller supplies PC+1 of the control instruction)
- imm  in  IMM_WIDTH  signed branch offset
- target  in  TARGET_WIDTH  jump target field
- reg_target  in  WIDTH  register-indirect target
- push_valid  in  1  push push_addr onto RAS
- push_addr  in  WIDTH  return address to push
- pc  out  WIDTH  current PC (registered)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_underflow  out  1  one-cycle pulse: return popped an empty RAS
- ras_overflow  out  1  sticky: push occurred while full

## Operation
- Target computation (combinational, internal):
  - sel 0 → base + sign_extend(imm), modulo 2^WIDTH
  - sel 1 → {base[WIDTH-1:TARGET_WIDTH], target}
  - sel 2 → reg_target
  - sel 3 → RAS top, or reg_target if the RAS is empty
- PC update priority: reset > redirect_valid > stall > increment.
  - redirect_valid wins over stall.
  - Increment wraps 0xFFFF → 0x0000 (all-ones → 0 generally).
- RAS is a circular buffer with a top pointer and a count.
- Push: write push_addr at top+1 and advance top.
  - count saturates at RAS_DEPTH.
  - Push while full overwrites the oldest entry and sets ras_overflow.
- Pop: occurs on redirect_valid with sel 3.
  - Target is the current top; decrement top and count.
  - Pop while empty: target = reg_target, count stays 0, ras_underflow pulses on the next cycle.
- Simultaneous push and pop: the pop target is the pre-push top; the top entry is replaced by push_addr; count unchanged. Pop-on-empty plus push leaves count 1.
- Push and pop act regardless of stall.
- Reset values: pc = RESET_PC, ras_count = 0, ras_underflow = 0, ras_overflow = 0. RAS contents are don't-care.

## Timing
- Single clock domain; no combinational path from inputs to outputs. All outputs are registered.
- Redirect latency: 1 cycle. Target inputs sampled at edge N; pc shows the target after edge N.
- Stall: pc holds at the sampled edge. Deasserting stall resumes increment at the next edge.
- ras_count reflects push/pop after the same edge. The pop target uses pre-edge contents.
- ras_underflow is high for exactly one cycle after the offending edge.
- Reset mid-operation: next edge forces all reset values, overriding any redirect, push or pop in that cycle.

## Configuration
- Macro: PC_GEN_RAS_EN.
- Defined: RAS implemented as above.
- Undefined:
  - No RAS storage.
  - sel 3 behaves exactly as sel 2.
  - push_valid/push_addr ignored.
  - ras_count, ras_underflow, ras_overflow tied to 0.
- Ports are identical in both builds.

## Test plan
All with defaults WIDTH=16, IMM_WIDTH=8, TARGET_WIDTH=12, RESET_PC=0, RAS_DEPTH=4.
- Reset 1 cycle, then free-run 3 cycles → pc 0x0000, 0x0001, 0x0002, 0x0003. Stall 2 cycles → pc holds 0x0003.
- Branch: base=0x0010, imm=0xFE, stall=1, redirect sel 0 → pc 0x000E next cycle (redirect beats stall). imm=0x05 → 0x0015.
- Jump: base=0xA123, target=0x456, sel 1 → pc 0xA456. Register: reg_target=0xBEEF, sel 2 → pc 0xBEEF.
- Wrap: pc reaches 0xFFFF, no stall/redirect → next pc 0x0000.
- RAS (macro on):
  - Push 0x1000 then 0x2000 → ras_count 2.
  - Return → pc 0x2000, then return → pc 0x1000.
  - Return with reg_target=0x3333 → pc 0x3333, ras_underflow=1 for one cycle, count 0.
- RAS overflow/simultaneous (macro on):
  - Push 0x1..0x5 → count 4, ras_overflow=1.
  - Pops yield 0x5, 0x4, 0x3, 0x2.
  - Push 0x9 with a pop → pop target is the pre-push top, top becomes 0x9, count unchanged.
  - Reset → count 0, overflow 0.
  - Macro off: sel 3 equals sel 2, RAS flags stay 0.
